// File: rtl/circle_mover.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : circle_mover
// Purpose : Moves a circle centre once per frame, either under button control
//           or bouncing between the screen bounds, with a pause toggle.
// Rev     : 1.0  initial release
// ============================================================================
module circle_mover #(
    parameter int HV   = 1920,
    parameter int VV   = 1080,
    parameter int RAZA = 120,
    parameter int STEP = 4
) (
    input  logic               clk_148Mhz,
    input  logic               reset,
    input  logic               v_sync,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_center,
    input  logic               sw_auto,
    output logic signed [11:0] x_pos,
    output logic signed [11:0] y_pos,
    output logic               frame_tick,
    output logic               paused
);

    localparam logic signed [12:0] c_x_min = 13'(RAZA);
    localparam logic signed [12:0] c_x_max = 13'(HV - 1 - RAZA);
    localparam logic signed [12:0] c_y_min = 13'(RAZA);
    localparam logic signed [12:0] c_y_max = 13'(VV - 1 - RAZA);
    localparam logic signed [12:0] c_step  = 13'(STEP);
    localparam logic signed [11:0] c_x_rst = 12'(HV / 2);
    localparam logic signed [11:0] c_y_rst = 12'(VV / 2);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_PAUSE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [5:0]         r_sync1;
    logic [5:0]         r_sync2;
    logic               r_vs;
    logic               r_center_prev;
    logic               r_dir_x;
    logic               r_dir_y;
    logic               w_dir_x_next;
    logic               w_dir_y_next;
    logic signed [11:0] w_x_next;
    logic signed [11:0] w_y_next;
    logic signed [12:0] w_x_ext;
    logic signed [12:0] w_y_ext;
    logic signed [12:0] w_dx;
    logic signed [12:0] w_dy;
    logic signed [12:0] w_x_auto;
    logic signed [12:0] w_y_auto;
    logic               w_up, w_down, w_left, w_right, w_center, w_auto;
    logic               w_press;

    // Saturate in 13 bits so the 12-bit result can never wrap.
    function automatic logic signed [11:0] f_clamp(input logic signed [12:0] v,
                                                   input logic signed [12:0] lo,
                                                   input logic signed [12:0] hi);
        if (v < lo)
            f_clamp = lo[11:0];
        else if (v > hi)
            f_clamp = hi[11:0];
        else
            f_clamp = v[11:0];
    endfunction

    always_ff @(posedge clk_148Mhz) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {sw_auto, btn_center, btn_right, btn_left, btn_down, btn_up};
            r_sync2 <= r_sync1;
        end
    end

    assign {w_auto, w_center, w_right, w_left, w_down, w_up} = r_sync2;

    always_ff @(posedge clk_148Mhz) begin
        if (reset) begin
            r_vs       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            r_vs       <= v_sync;
            frame_tick <= v_sync & ~r_vs;
        end
    end

    assign w_press  = w_center & ~r_center_prev;
    assign w_x_ext  = 13'(x_pos);
    assign w_y_ext  = 13'(y_pos);
    // Opposing buttons cancel on their own axis only.
    assign w_dx     = (w_right & ~w_left) ? c_step : (w_left & ~w_right) ? -c_step : 13'sd0;
    assign w_dy     = (w_down & ~w_up)    ? c_step : (w_up & ~w_down)    ? -c_step : 13'sd0;
    assign w_x_auto = w_x_ext + (r_dir_x ? c_step : -c_step);
    assign w_y_auto = w_y_ext + (r_dir_y ? c_step : -c_step);

    always_comb begin
        w_state_next = r_state;
        w_x_next     = x_pos;
        w_y_next     = y_pos;
        w_dir_x_next = r_dir_x;
        w_dir_y_next = r_dir_y;
        if (frame_tick) begin
            case (r_state)
                ST_MANUAL: begin
                    if (w_press) begin
                        w_state_next = ST_PAUSE;
                    end else begin
                        if (w_auto)
                            w_state_next = ST_AUTO;
                        w_x_next = f_clamp(w_x_ext + w_dx, c_x_min, c_x_max);
                        w_y_next = f_clamp(w_y_ext + w_dy, c_y_min, c_y_max);
                    end
                end
                ST_AUTO: begin
                    if (w_press) begin
                        w_state_next = ST_PAUSE;
                    end else begin
                        if (!w_auto)
                            w_state_next = ST_MANUAL;
                        // Reaching a bound exactly also reverses direction.
                        w_x_next = f_clamp(w_x_auto, c_x_min, c_x_max);
                        w_y_next = f_clamp(w_y_auto, c_y_min, c_y_max);
                        if (w_x_auto >= c_x_max)
                            w_dir_x_next = 1'b0;
                        else if (w_x_auto <= c_x_min)
                            w_dir_x_next = 1'b1;
                        if (w_y_auto >= c_y_max)
                            w_dir_y_next = 1'b0;
                        else if (w_y_auto <= c_y_min)
                            w_dir_y_next = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_press)
                        w_state_next = w_auto ? ST_AUTO : ST_MANUAL;
                end
                default: w_state_next = ST_MANUAL;
            endcase
        end
    end

    always_ff @(posedge clk_148Mhz) begin
        if (reset) begin
            r_state       <= ST_MANUAL;
            r_center_prev <= 1'b0;
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b1;
            x_pos         <= c_x_rst;
            y_pos         <= c_y_rst;
        end else begin
            r_state       <= w_state_next;
            r_dir_x       <= w_dir_x_next;
            r_dir_y       <= w_dir_y_next;
            x_pos         <= w_x_next;
            y_pos         <= w_y_next;
            if (frame_tick)
                r_center_prev <= w_center;
        end
    end

    assign paused = (r_state == ST_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_circle_mover.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_circle_mover
// Purpose : Scoreboard bench for circle_mover; a default instance plus one with
//           an odd centre so the 1797 -> 1799 clamp/bounce cases are reachable.
// Rev     : 1.0  initial release
// ============================================================================
module tb_circle_mover;

    logic clk_148Mhz = 1'b0;
    logic reset      = 1'b1;
    logic v_sync     = 1'b0;
    logic btn_up     = 1'b0;
    logic btn_down   = 1'b0;
    logic btn_left   = 1'b0;
    logic btn_right  = 1'b0;
    logic btn_center = 1'b0;
    logic sw_auto    = 1'b0;

    logic signed [11:0] xa, ya, xb, yb;
    logic fta, ftb, pa, pb;

    always #5 clk_148Mhz = ~clk_148Mhz;

    circle_mover dut_a (
        .clk_148Mhz(clk_148Mhz), .reset(reset), .v_sync(v_sync),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center), .sw_auto(sw_auto),
        .x_pos(xa), .y_pos(ya), .frame_tick(fta), .paused(pa)
    );

    // HV=1922, RAZA=122: centre 961, X bounds 122..1799, Y bounds 122..957.
    circle_mover #(.HV(1922), .VV(1080), .RAZA(122), .STEP(4)) dut_b (
        .clk_148Mhz(clk_148Mhz), .reset(reset), .v_sync(v_sync),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center), .sw_auto(sw_auto),
        .x_pos(xb), .y_pos(yb), .frame_tick(ftb), .paused(pb)
    );

    typedef struct {
        int xa;
        int ya;
        int xb;
        int yb;
        bit p;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ticks = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each tick pops one expectation and checks the post-update outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_148Mhz); #1;
            if (fta === 1'b1) begin
                n_ticks++;
                check("tick_b_align", int'(ftb), 1);
                @(posedge clk_148Mhz); #1;
                check("tick_width", int'(fta), 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tick: got tick %0d, expected none", n_ticks);
                end else begin
                    e = exp_q.pop_front();
                    check("x_a", int'(xa), e.xa);
                    check("y_a", int'(ya), e.ya);
                    check("x_b", int'(xb), e.xb);
                    check("y_b", int'(yb), e.yb);
                    check("paused_a", int'(pa), int'(e.p));
                    check("paused_b", int'(pb), int'(e.p));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic frame();
        repeat (2) @(negedge clk_148Mhz);
        v_sync = 1'b1;
        repeat (3) @(negedge clk_148Mhz);
        v_sync = 1'b0;
        repeat (2) @(negedge clk_148Mhz);
    endtask

    task automatic frame_exp(input int exa, input int eya, input int exb, input int eyb,
                             input bit ep);
        exp_t e;
        e.xa = exa; e.ya = eya; e.xb = exb; e.yb = eyb; e.p = ep;
        exp_q.push_back(e);
        frame();
    endtask

    task automatic do_reset();
        @(negedge clk_148Mhz);
        reset = 1'b1;
        repeat (3) @(negedge clk_148Mhz);
        reset = 1'b0;
        @(negedge clk_148Mhz);
    endtask

    initial begin
        exp_t e;
        repeat (4) @(negedge clk_148Mhz);
        check("rst_x_a", int'(xa), 960);
        check("rst_y_a", int'(ya), 540);
        check("rst_x_b", int'(xb), 961);
        check("rst_y_b", int'(yb), 540);
        check("rst_tick", int'(fta), 0);
        check("rst_paused", int'(pa), 0);
        reset = 1'b0;
        @(negedge clk_148Mhz);

        for (int i = 0; i < 3; i++)
            frame_exp(960, 540, 961, 540, 1'b0);
        check("tick_count", n_ticks, 3);

        btn_right = 1'b1;
        for (int i = 1; i <= 10; i++)
            frame_exp(960 + 4 * i, 540, 961 + 4 * i, 540, 1'b0);
        btn_left = 1'b1;
        frame_exp(1000, 540, 1001, 540, 1'b0);
        frame_exp(1000, 540, 1001, 540, 1'b0);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_up    = 1'b1;
        frame_exp(1000, 536, 1001, 536, 1'b0);
        btn_down  = 1'b1;
        frame_exp(1000, 536, 1001, 536, 1'b0);
        btn_up    = 1'b0;
        frame_exp(1000, 540, 1001, 540, 1'b0);
        btn_down  = 1'b0;

        // Manual clamp at X_MAX: dut_b reaches 1797, dut_a 1796.
        do_reset();
        btn_right = 1'b1;
        for (int i = 1; i <= 209; i++)
            frame_exp(960 + 4 * i, 540, 961 + 4 * i, 540, 1'b0);
        frame_exp(1799, 540, 1799, 540, 1'b0);
        frame_exp(1799, 540, 1799, 540, 1'b0);
        btn_right = 1'b0;

        // Bounce at X_MAX after switching to auto.
        do_reset();
        btn_right = 1'b1;
        for (int i = 1; i <= 209; i++)
            frame_exp(960 + 4 * i, 540, 961 + 4 * i, 540, 1'b0);
        btn_right = 1'b0;
        sw_auto   = 1'b1;
        frame_exp(1796, 540, 1797, 540, 1'b0);
        frame_exp(1799, 544, 1799, 544, 1'b0);
        frame_exp(1795, 548, 1795, 548, 1'b0);
        frame_exp(1791, 552, 1791, 552, 1'b0);

        // Pause / resume.
        btn_center = 1'b1;
        frame_exp(1791, 552, 1791, 552, 1'b1);
        btn_center = 1'b0;
        for (int i = 0; i < 5; i++)
            frame_exp(1791, 552, 1791, 552, 1'b1);
        btn_center = 1'b1;
        frame_exp(1791, 552, 1791, 552, 1'b0);
        btn_center = 1'b0;
        frame_exp(1787, 556, 1787, 556, 1'b0);
        frame_exp(1783, 560, 1783, 560, 1'b0);

        // Reset landing on the frame_tick cycle wins over movement.
        btn_right = 1'b1;
        e.xa = 960; e.ya = 540; e.xb = 961; e.yb = 540; e.p = 1'b0;
        exp_q.push_back(e);
        repeat (2) @(negedge clk_148Mhz);
        v_sync = 1'b1;
        @(posedge clk_148Mhz); #1;
        reset = 1'b1;
        @(negedge clk_148Mhz);
        v_sync = 1'b0;
        repeat (2) @(negedge clk_148Mhz);
        check("coinc_x_a", int'(xa), 960);
        check("coinc_x_b", int'(xb), 961);
        check("coinc_tick", int'(fta), 0);
        check("coinc_paused", int'(pa), 0);
        sw_auto   = 1'b0;
        btn_right = 1'b0;
        reset     = 1'b0;
        @(negedge clk_148Mhz);
        frame_exp(960, 540, 961, 540, 1'b0);
        btn_right = 1'b1;
        frame_exp(964, 540, 965, 540, 1'b0);
        btn_right = 1'b0;

        for (int k = 0; k < 100 && exp_q.size() != 0; k++)
            @(negedge clk_148Mhz);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/circle_mover.md
CIRCLE_MOVER -- requirements
Module: circle_mover

Interface
REQ-001 SHALL have parameter HV, default 1920: visible width in pixels.
REQ-002 SHALL have parameter VV, default 1080: visible height in lines.
REQ-003 SHALL have parameter RAZA, default 120: circle radius in pixels.
REQ-004 SHALL have parameter STEP, default 4: movement in pixels per frame.
REQ-005 SHALL have port clk_148Mhz, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port v_sync, input, 1 bit: vertical sync from the raster generator, in the same clock domain.
REQ-008 SHALL have ports btn_up, btn_down, btn_left and btn_right, input, 1 bit each: raw asynchronous push-buttons, active-high.
REQ-009 SHALL have port btn_center, input, 1 bit: raw asynchronous pause/resume button.
REQ-010 SHALL have port sw_auto, input, 1 bit: raw asynchronous switch; 1 selects bounce mode, 0 selects manual mode.
REQ-011 SHALL have port x_pos, output, signed 12 bits: circle centre X, registered.
REQ-012 SHALL have port y_pos, output, signed 12 bits: circle centre Y, registered.
REQ-013 SHALL have port frame_tick, output, 1 bit: one-cycle pulse per frame, registered.
REQ-014 SHALL have port paused, output, 1 bit: high while the state is PAUSE.

Function
REQ-015 SHALL pass all six raw inputs through two-flop synchronizers before any use.
REQ-016 SHALL register v_sync once; frame_tick SHALL be high for exactly one cycle, the cycle after a 0->1 edge of v_sync is seen.
REQ-017 SHALL sample buttons and switch only on frame_tick; this frame-rate sampling is the only debounce.
REQ-018 SHALL update x_pos and y_pos only on the clock edge that ends a frame_tick cycle; x_pos/y_pos therefore change 2 cycles after the v_sync rise.
REQ-019 SHALL use bounds X_MIN=RAZA, X_MAX=HV-1-RAZA, Y_MIN=RAZA, Y_MAX=VV-1-RAZA (defaults 120, 1799, 120, 959).
REQ-020 SHALL implement an FSM with states MANUAL, AUTO and PAUSE; transitions occur only on frame_tick.
REQ-021 SHALL detect a btn_center press as sampled 1 on this tick and 0 on the previous tick.
REQ-022 In MANUAL or AUTO, a btn_center press SHALL go to PAUSE; in PAUSE, a press SHALL go to AUTO if sw_auto=1, else to MANUAL.
REQ-023 In MANUAL, sw_auto=1 SHALL go to AUTO; in AUTO, sw_auto=0 SHALL go to MANUAL; a btn_center press takes priority over the switch.
REQ-024 A state change SHALL take effect on the following tick; the tick that causes the transition moves the circle per the old state, except that entry into PAUSE freezes the position on that same tick.
REQ-025 In MANUAL, each held button SHALL move the position by STEP per tick (up: Y-STEP, down: Y+STEP, left: X-STEP, right: X+STEP), with the result clamped to the bounds.
REQ-026 In MANUAL, opposing buttons held together SHALL cause no motion on that axis; the other axis is unaffected.
REQ-027 In AUTO, each axis SHALL move STEP per tick in its direction register (dir_x, dir_y; 1 means +).
REQ-028 In AUTO, if the next value would pass the max, the position SHALL be set to the max and the direction flips to -; if it would pass the min, the position SHALL be set to the min and the direction flips to +.
REQ-029 In AUTO, landing exactly on a bound SHALL flip the direction; the next tick then moves away from that bound.
REQ-030 In PAUSE, the position and direction registers SHALL hold their values.
REQ-031 Arithmetic SHALL be done in 13-bit signed with clamping before truncation to 12 bits; no wrap-around is permitted.
REQ-032 Direction registers SHALL persist through MANUAL and PAUSE.

Reset
REQ-033 On reset: x_pos=HV/2 (960), y_pos=VV/2 (540), dir_x=1, dir_y=1, state=MANUAL, frame_tick=0, paused=0, synchronizer and edge registers=0.
REQ-034 Reset mid-frame SHALL have priority over a coincident frame_tick; the first post-reset v_sync edge SHALL be detected normally.

Verification
REQ-035 Bench SHALL check: reset, then 3 v_sync rises with no buttons -> x_pos=960, y_pos=540; frame_tick pulses 3 times, each 1 cycle wide.
REQ-036 Bench SHALL check: btn_right held for 10 frames -> x_pos=1000; btn_left+btn_right held together -> x_pos unchanged.
REQ-037 Bench SHALL check: MANUAL, x_pos=1797, btn_right held for 2 frames -> 1799 then 1799 (clamped).
REQ-038 Bench SHALL check: sw_auto=1 with x=1797, dir_x=1 -> next ticks give 1799 (dir flips), then 1795, then 1791.
REQ-039 Bench SHALL check: btn_center pulse in AUTO -> paused=1 and position frozen over 5 frames; second pulse -> AUTO resumes from the frozen position.
REQ-040 Bench SHALL check: reset asserted in the same cycle as frame_tick -> outputs equal reset values, and no movement is applied.
